// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA are
//            queued in a DEPTH-entry FIFO and shifted out LSB first on txd,
//            with a bit period of DIVISOR+1 clocks. DIVISOR is latched at the
//            start of each frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   uart_valid  in   request from the address decoder
//   uart_instr  in   instruction-fetch flag (ignored)
//   uart_addr   in   offset-relative byte address
//   uart_wdata  in   write data
//   uart_wstrb  in   byte write strobes, 0 = read
//   uart_rdata  out  read data, valid while uart_ready=1
//   uart_ready  out  single-cycle response pulse
//   uart_txd    out  serial output, idle high
// Register map (uart_addr[3:2])
//   0x0 TXDATA  (W)  push wdata[7:0]
//   0x4 STATUS  (R)  {COUNT[15:8], OVF[3], BUSY[2], EMPTY[1], FULL[0]}
//   0x8 DIVISOR (RW) 16 bits
// ============================================================================
module uart_tx #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DIV_RESET = 16'd15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_txd
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bus decode
    logic        accept;
    logic        is_write;
    logic        is_read;
    logic        in_range;
    logic [1:0]  reg_sel;
    logic [31:0] read_value;

    // FIFO
    logic [7:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;

    // Control registers
    logic          ovf;
    logic [15:0]   divisor;

    // Transmitter
    logic [1:0]    state;
    logic [15:0]   period;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Inputs that carry no meaning for this slave.
    logic unused_bits;
    assign unused_bits = ^{uart_instr, uart_addr[1:0], uart_wdata[31:16], uart_wstrb[3:2]};

    // An edge presenting a response never accepts, so a held valid
    // produces one response every two cycles.
    assign accept   = uart_valid && !uart_ready;
    assign is_write = accept && (uart_wstrb != 4'd0);
    assign is_read  = accept && (uart_wstrb == 4'd0);
    assign in_range = (uart_addr[31:4] == 28'd0);
    assign reg_sel  = uart_addr[3:2];

    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);

    // FULL is judged on the pre-edge count, so a push in the pop cycle of a
    // full FIFO is still dropped.
    assign push_req = is_write && in_range && (reg_sel == 2'd0) && uart_wstrb[0];
    assign push     = push_req && !fifo_full;
    assign pop      = (state == ST_IDLE) && !fifo_empty;

    always_comb begin
        read_value = '0;
        if (in_range) begin
            case (reg_sel)
                2'd1:    read_value = {16'h0000, 8'(count), 4'h0, ovf,
                                       (state != ST_IDLE), fifo_empty, fifo_full};
                2'd2:    read_value = {16'h0000, divisor};
                default: read_value = '0;
            endcase
        end
    end

    // Bus response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uart_ready <= 1'b0;
            uart_rdata <= '0;
        end else begin
            uart_ready <= accept;
            uart_rdata <= is_read ? read_value : 32'd0;
        end
    end

    // DIVISOR and sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
        end else begin
            if (is_write && in_range && (reg_sel == 2'd2)) begin
                if (uart_wstrb[0]) divisor[7:0]  <= uart_wdata[7:0];
                if (uart_wstrb[1]) divisor[15:8] <= uart_wdata[15:8];
            end
            // STATUS has already captured the old OVF into rdata this edge.
            if (push_req && fifo_full) begin
                ovf <= 1'b1;
            end else if (is_read && in_range && (reg_sel == 2'd1)) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= uart_wdata[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Transmit FSM. txd is registered; each state's level is loaded on the
    // transition into it so the line changes exactly at state boundaries.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            uart_txd <= 1'b1;
            period   <= '0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    uart_txd <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_mem[rd_ptr];
                        period   <= divisor;
                        bit_cnt  <= '0;
                        uart_txd <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_cnt == period) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                        state    <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == period) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= ST_STOP;
                        end else begin
                            shift    <= {1'b0, shift[7:1]};
                            bit_idx  <= bit_idx + 1'b1;
                            uart_txd <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == period) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    uart_txd <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. A frame-level behavioural model
//            predicts ready/rdata/txd every cycle; directed scenarios add
//            hand-computed literal checks on the serial waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DEPTH = 8;
    localparam int HIST  = 8192;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        uart_valid = 1'b0;
    logic        uart_instr = 1'b0;
    logic [31:0] uart_addr  = '0;
    logic [31:0] uart_wdata = '0;
    logic [3:0]  uart_wstrb = '0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_txd;

    uart_tx #(.DEPTH(DEPTH), .DIV_RESET(16'd15)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_txd   (uart_txd)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_ready;
    logic [31:0] m_rdata;
    logic [7:0]  m_q[$];
    bit          m_ovf;
    logic [15:0] m_div;
    bit          m_active;
    logic [9:0]  m_frame;
    int          m_fdiv;
    int          m_pos;

    task automatic model_reset();
        m_ready  = 1'b0;
        m_rdata  = '0;
        m_q.delete();
        m_ovf    = 1'b0;
        m_div    = 16'd15;
        m_active = 1'b0;
        m_frame  = '1;
        m_fdiv   = 0;
        m_pos    = 0;
    endtask

    function automatic bit model_txd();
        if (!m_active) return 1'b1;
        return m_frame[m_pos / (m_fdiv + 1)];
    endfunction

    task automatic model_step();
        bit          acc;
        bit          wr;
        bit          rd;
        bit          inr;
        bit          full_pre;
        bit          do_pop;
        int          cnt;
        logic [31:0] rv;
        logic [7:0]  b;
        acc      = uart_valid && !m_ready;
        wr       = acc && (uart_wstrb != 4'd0);
        rd       = acc && (uart_wstrb == 4'd0);
        inr      = (uart_addr < 32'h10);
        cnt      = m_q.size();
        full_pre = (cnt == DEPTH);
        do_pop   = !m_active && (cnt > 0);
        rv = '0;
        if (rd && inr) begin
            if (uart_addr[3:2] == 2'd1)
                rv = {16'h0, 8'(cnt), 4'h0, m_ovf, m_active, (cnt == 0), full_pre};
            else if (uart_addr[3:2] == 2'd2)
                rv = {16'h0, m_div};
        end
        // a frame is 10 bit slots of (div+1) cycles, then one idle cycle
        if (m_active) begin
            m_pos++;
            if (m_pos == 10 * (m_fdiv + 1)) m_active = 1'b0;
        end
        if (do_pop) begin
            b        = m_q.pop_front();
            m_frame  = {1'b1, b, 1'b0};
            m_fdiv   = int'(m_div);
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (wr && inr) begin
            if (uart_addr[3:2] == 2'd0 && uart_wstrb[0]) begin
                if (full_pre) m_ovf = 1'b1;
                else          m_q.push_back(uart_wdata[7:0]);
            end
            if (uart_addr[3:2] == 2'd2) begin
                if (uart_wstrb[0]) m_div[7:0]  = uart_wdata[7:0];
                if (uart_wstrb[1]) m_div[15:8] = uart_wdata[15:8];
            end
        end
        if (rd && inr && uart_addr[3:2] == 2'd1) m_ovf = 1'b0;
        m_ready = acc;
        m_rdata = rv;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor + per-cycle compare ----------------
    int   cyc = 0;
    logic tx_hist [HIST];
    int   fall_q[$];
    logic prev_txd = 1'b1;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (cyc < HIST) tx_hist[cyc] = uart_txd;
            if (prev_txd === 1'b1 && uart_txd === 1'b0) fall_q.push_back(cyc);
            prev_txd = uart_txd;
            check("txd", {31'h0, uart_txd}, {31'h0, model_txd()});
            check("ready", {31'h0, uart_ready}, {31'h0, m_ready});
            if (m_ready || !reset) check("rdata", uart_rdata, m_rdata);
        end
    end

    // ---------------- helpers ----------------
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        @(negedge clock);
        uart_valid = 1'b1;
        uart_addr  = a;
        uart_wdata = d;
        uart_wstrb = s;
        @(negedge clock);
        r = uart_rdata;
        uart_valid = 1'b0;
        uart_wstrb = 4'd0;
    endtask

    task automatic wait_fall(input int n0, output int f);
        int guard;
        guard = 0;
        while (fall_q.size() <= n0 && guard < 600) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (fall_q.size() > n0) begin
            f = fall_q[n0];
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_bit_timeout: no start bit within 600 cycles");
            f = cyc;
        end
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (cyc < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cycle_wait_timeout: cycle %0d required %0d", cyc, target);
        end
    endtask

    function automatic logic hist(input int i);
        if (i < 0 || i >= HIST) return 1'bx;
        return tx_hist[i];
    endfunction

    // sample each data bit in the middle of its slot
    function automatic logic [7:0] decode(input int f, input int div);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = hist(f + (i + 1) * (div + 1) + div / 2);
        return b;
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [9:0]  fr;
        int          n0;
        int          f;
        int          f1;
        int          nf;
        bit          quiet;

        // 1: reset values and register reads
        repeat (3) @(negedge clock);
        check("reset_txd", {31'h0, uart_txd}, 32'd1);
        check("reset_ready", {31'h0, uart_ready}, 32'd0);
        check("reset_rdata", uart_rdata, 32'd0);
        reset = 1'b1;
        bus(32'h4, 0, 4'd0, r);  check("t1_status", r, 32'h0000_0002);
        bus(32'h8, 0, 4'd0, r);  check("t1_divisor", r, 32'd15);
        bus(32'hC, 0, 4'd0, r);  check("t1_reserved", r, 32'd0);
        bus(32'h14, 0, 4'd0, r); check("t1_out_of_range", r, 32'd0);
        bus(32'h0, 0, 4'd0, r);  check("t1_txdata_read", r, 32'd0);

        // 2: one 0xA5 frame at DIVISOR=3
        bus(32'h8, 32'd3, 4'b0001, r);
        n0 = fall_q.size();
        bus(32'h0, 32'hA5, 4'b0001, r);
        bus(32'h4, 0, 4'd0, r);  check("t2_status_busy_empty", r, 32'h0000_0006);
        wait_fall(n0, f);
        wait_cyc(f + 45);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++)
            check($sformatf("t2_wave_%0d", k), {31'h0, hist(f + k)}, {31'h0, fr[k / 4]});
        check("t2_idle_after", {31'h0, hist(f + 40)}, 32'd1);
        bus(32'h4, 0, 4'd0, r);  check("t2_status_idle", r, 32'h0000_0002);

        // 3: overflow; bytes 0x00..0x08 pushed behind a slow 0x5A frame
        n0 = fall_q.size();
        bus(32'h0, 32'h5A, 4'b0001, r);
        bus(32'h8, 32'd0, 4'b0011, r);
        for (int i = 0; i < 9; i++) bus(32'h0, 32'(i), 4'b0001, r);
        bus(32'h4, 0, 4'd0, r);  check("t3_status_ovf", r, 32'h0000_080D);
        bus(32'h4, 0, 4'd0, r);  check("t3_status_ovf_cleared", r, 32'h0000_0805);
        wait_fall(n0, f);
        wait_cyc(f + 41 + 88 + 22);
        check("t3_first_byte", {24'h0, decode(f, 3)}, 32'h5A);
        for (int k = 0; k < 8; k++)
            check($sformatf("t3_byte_%0d", k), {24'h0, decode(f + 41 + 11 * k, 0)}, 32'(k));
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) if (hist(f + 41 + 88 + k) !== 1'b1) quiet = 1'b0;
        check("t3_dropped_byte_not_sent", {31'h0, quiet}, 32'd1);

        // 4: valid held for six cycles on a TXDATA write
        n0 = fall_q.size();
        @(negedge clock);
        uart_valid = 1'b1;
        uart_addr  = 32'h0;
        uart_wdata = 32'h3C;
        uart_wstrb = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            check($sformatf("t4_ready_%0d", k), {31'h0, uart_ready}, 32'(k % 2));
        end
        uart_valid = 1'b0;
        uart_wstrb = 4'd0;
        bus(32'h4, 0, 4'd0, r);  check("t4_status_count", r, 32'h0000_0204);
        wait_fall(n0, f);
        wait_cyc(f + 40);
        for (int k = 0; k < 3; k++)
            check($sformatf("t4_byte_%0d", k), {24'h0, decode(f + 11 * k, 0)}, 32'h3C);

        // 5: DIVISOR change mid-frame only affects the next frame
        repeat (10) @(negedge clock);
        n0 = fall_q.size();
        bus(32'h8, 32'd3, 4'b0001, r);
        bus(32'h0, 32'h96, 4'b0001, r);
        bus(32'h0, 32'h69, 4'b0001, r);
        bus(32'h8, 32'd1, 4'b0001, r);
        wait_fall(n0, f1);
        wait_cyc(f1 + 41 + 30);
        check("t5_byte0", {24'h0, decode(f1, 3)}, 32'h96);
        check("t5_stop0", {31'h0, hist(f1 + 40)}, 32'd1);
        check("t5_start1_a", {31'h0, hist(f1 + 41)}, 32'd0);
        check("t5_start1_b", {31'h0, hist(f1 + 42)}, 32'd0);
        check("t5_bit0_frame1", {31'h0, hist(f1 + 43)}, 32'd1);
        check("t5_byte1", {24'h0, decode(f1 + 41, 1)}, 32'h69);
        check("t5_stop1", {31'h0, hist(f1 + 41 + 19)}, 32'd1);
        check("t5_idle1", {31'h0, hist(f1 + 41 + 20)}, 32'd1);

        // 6: asynchronous reset during data bit 4 with three bytes queued
        repeat (10) @(negedge clock);
        n0 = fall_q.size();
        bus(32'h8, 32'd3, 4'b0001, r);
        bus(32'h0, 32'h0F, 4'b0001, r);
        bus(32'h0, 32'h22, 4'b0001, r);
        bus(32'h0, 32'h33, 4'b0001, r);
        bus(32'h0, 32'h44, 4'b0001, r);
        wait_fall(n0, f);
        wait_cyc(f + 21);
        check("t6_bit4_low", {31'h0, uart_txd}, 32'd0);
        reset = 1'b0;
        #1;
        check("t6_async_txd", {31'h0, uart_txd}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        bus(32'h4, 0, 4'd0, r);  check("t6_status", r, 32'h0000_0002);
        bus(32'h8, 0, 4'd0, r);  check("t6_divisor", r, 32'd15);
        nf = fall_q.size();
        repeat (80) @(negedge clock);
        check("t6_no_frames", 32'(fall_q.size()), 32'(nf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
